// File: rtl/change_dispenser.sv
// Change dispenser: computes bal-cost in BCD, pays change out as timed coin pulses and
// scans the result on a 4-digit display. Define CHANGE_CHIRP_EN to enable the buzzer chirp.
module change_dispenser #(
    parameter int unsigned PULSE_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES   = 50000000,
    parameter int unsigned SCAN_CYCLES  = 100000,
    parameter int unsigned CHIRP_CYCLES = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phase_on,
    input  logic        confirm,
    input  logic [11:0] bal,
    input  logic [11:0] cost,
    output logic        coin_100,
    output logic        coin_10,
    output logic        coin_1,
    output logic        owe,
    output logic [11:0] change,
    output logic [7:0]  led,
    output logic [3:0]  ena,
    output logic        buzzer,
    output logic        next
);

    // state   | meaning
    // IDLE    | waiting for phase_on, inputs captured on entry to CALC
    // CALC    | one-cycle BCD subtract, sets change/owe
    // CONFIRM | waiting for the confirm button
    // DISP_H  | paying out hundreds on coin_100
    // DISP_T  | paying out tens on coin_10
    // DISP_O  | paying out ones on coin_1
    // DONE    | next held high until phase_on drops
    typedef enum logic [2:0] {IDLE, CALC, CONFIRM, DISP_H, DISP_T, DISP_O, DONE} state_t;
    typedef enum logic [1:0] {PH_CHK, PH_HIGH, PH_LOW} phase_t;

    localparam logic [31:0] PULSE_LOAD = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] SCAN_LOAD  = 32'(SCAN_CYCLES - 1);

    state_t      state, state_nxt;
    phase_t      ph;
    logic [31:0] tmr;
    logic [31:0] scan_cnt;
    logic [1:0]  scan_idx;
    logic [11:0] bal_q, cost_q;
    logic [3:0]  cur_digit;
    logic [11:0] dec_unit;
    logic        tmr_tc;
    logic        owe_calc;
    logic        coin_start;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Digit-wise subtract with borrow; caller guarantees a >= b.
    function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] r;
        logic [4:0]  t;
        logic        brw;
        r   = '0;
        brw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, brw};
            if (t[4]) begin
                r[i*4 +: 4] = t[3:0] + 4'd10;
                brw         = 1'b1;
            end else begin
                r[i*4 +: 4] = t[3:0];
                brw         = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    assign tmr_tc   = (tmr == '0);
    assign owe_calc = (cost_q > bal_q);

    always_comb begin
        cur_digit = 4'd0;
        dec_unit  = 12'h000;
        case (state)
            DISP_H:  begin cur_digit = change[11:8]; dec_unit = 12'h100; end
            DISP_T:  begin cur_digit = change[7:4];  dec_unit = 12'h010; end
            DISP_O:  begin cur_digit = change[3:0];  dec_unit = 12'h001; end
            default: ;
        endcase
    end

    // A coin rises from the check slot or directly at gap end, so same-digit gaps stay exact.
    assign coin_start = (state == DISP_H || state == DISP_T || state == DISP_O) && phase_on &&
                        (cur_digit != 4'd0) && (ph == PH_CHK || (ph == PH_LOW && tmr_tc));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (phase_on) state_nxt = CALC;
            CALC:    state_nxt = CONFIRM;
            CONFIRM: if (confirm) state_nxt = (owe || change == 12'h000) ? DONE : DISP_H;
            DISP_H:  if (ph == PH_CHK && cur_digit == 4'd0) state_nxt = DISP_T;
            DISP_T:  if (ph == PH_CHK && cur_digit == 4'd0) state_nxt = DISP_O;
            DISP_O:  if (ph == PH_CHK && cur_digit == 4'd0) state_nxt = DONE;
            DONE:    ;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && !phase_on) state_nxt = IDLE;
    end

    always_comb begin
        coin_100 = (state == DISP_H) && (ph == PH_HIGH);
        coin_10  = (state == DISP_T) && (ph == PH_HIGH);
        coin_1   = (state == DISP_O) && (ph == PH_HIGH);
        next     = (state == DONE);
        led      = 8'h00;
        ena      = 4'b0000;
        if (state != IDLE) begin
            ena = 4'b0001 << scan_idx;
            case (scan_idx)
                2'd0:    led = seg7(change[3:0]);
                2'd1:    led = seg7(change[7:4]);
                2'd2:    led = seg7(change[11:8]);
                default: led = owe ? 8'h79 : 8'h39;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bal_q  <= '0;
            cost_q <= '0;
            change <= '0;
            owe    <= 1'b0;
            ph     <= PH_CHK;
            tmr    <= '0;
        end else if (state != IDLE && !phase_on) begin
            change <= '0;
            owe    <= 1'b0;
            ph     <= PH_CHK;
            tmr    <= '0;
        end else begin
            case (state)
                IDLE: if (phase_on) begin
                    bal_q  <= {clamp9(bal[11:8]), clamp9(bal[7:4]), clamp9(bal[3:0])};
                    cost_q <= {clamp9(cost[11:8]), clamp9(cost[7:4]), clamp9(cost[3:0])};
                end
                CALC: begin
                    change <= owe_calc ? bcd_sub(cost_q, bal_q) : bcd_sub(bal_q, cost_q);
                    owe    <= owe_calc;
                end
                DISP_H, DISP_T, DISP_O: begin
                    if (coin_start) begin
                        ph  <= PH_HIGH;
                        tmr <= PULSE_LOAD;
                    end else begin
                        case (ph)
                            PH_HIGH: if (tmr_tc) begin
                                if (cur_digit != 4'd0) change <= change - dec_unit;
                                ph  <= PH_LOW;
                                tmr <= GAP_LOAD;
                            end else begin
                                tmr <= tmr - 32'd1;
                            end
                            PH_LOW: if (tmr_tc) ph <= PH_CHK;
                                    else        tmr <= tmr - 32'd1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
        end else if (state == IDLE) begin
            scan_cnt <= SCAN_LOAD;
            scan_idx <= 2'd0;
        end else if (scan_cnt == '0) begin
            scan_cnt <= SCAN_LOAD;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt - 32'd1;
        end
    end

`ifdef CHANGE_CHIRP_EN
    logic [31:0] chirp_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    chirp_cnt <= '0;
        else if (state_nxt == IDLE)  chirp_cnt <= '0;
        else if (coin_start)         chirp_cnt <= 32'(CHIRP_CYCLES);
        else if (chirp_cnt != '0)    chirp_cnt <= chirp_cnt - 32'd1;
    end

    assign buzzer = (chirp_cnt != '0);
`else
    assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser with short pulse/gap/scan timing.
module tb_change_dispenser;
    localparam int P = 4;
    localparam int G = 2;
    localparam int S = 3;
    localparam int C = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        phase_on = 1'b0;
    logic        confirm = 1'b0;
    logic [11:0] bal = 12'h000;
    logic [11:0] cost = 12'h000;
    logic        coin_100, coin_10, coin_1, owe, buzzer, next;
    logic [11:0] change;
    logic [7:0]  led;
    logic [3:0]  ena;

    int n_tests = 0;
    int n_fail  = 0;

    int cnt100, cnt10, cnt1, width_err, gap_err, order_err, multi_err, buzz_err, chirps;
    bit timed_out;
    bit found;
    int seen;

    always #5 clk = ~clk;

    change_dispenser #(
        .PULSE_CYCLES(P), .GAP_CYCLES(G), .SCAN_CYCLES(S), .CHIRP_CYCLES(C)
    ) dut (
        .clk(clk), .rst(rst), .phase_on(phase_on), .confirm(confirm),
        .bal(bal), .cost(cost),
        .coin_100(coin_100), .coin_10(coin_10), .coin_1(coin_1),
        .owe(owe), .change(change), .led(led), .ena(ena),
        .buzzer(buzzer), .next(next)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ena(input logic [3:0] e, output bit f);
        f = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ena === e) begin f = 1'b1; break; end
            tick();
        end
    endtask

    // Watches coin outputs each cycle until next rises or the given coin_10 count is reached.
    task automatic collect(input int budget, input int stop_c10);
        logic prev_any, prev_buz, any;
        int   hi, lo, last, code;
        prev_any = 1'b0; prev_buz = 1'b0; hi = 0; lo = 0; last = -1;
        cnt100 = 0; cnt10 = 0; cnt1 = 0; width_err = 0; gap_err = 0;
        order_err = 0; multi_err = 0; buzz_err = 0; chirps = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            any = coin_100 | coin_10 | coin_1;
            if (int'(coin_100) + int'(coin_10) + int'(coin_1) > 1) multi_err++;
            code = coin_100 ? 2 : (coin_10 ? 1 : 0);
            if (any && !prev_any) begin
                if (last >= 0 && code > last) order_err++;
                if (last == code && lo != G) gap_err++;
                if (code == 2) cnt100++;
                else if (code == 1) cnt10++;
                else cnt1++;
`ifdef CHANGE_CHIRP_EN
                if (buzzer && !prev_buz) chirps++;
`endif
                hi = 1; last = code;
            end else if (any) begin
                hi++;
            end else if (prev_any) begin
                if (hi != P) width_err++;
                lo = 1;
            end else begin
                lo++;
            end
`ifndef CHANGE_CHIRP_EN
            if (buzzer !== 1'b0) buzz_err++;
`endif
            prev_any = any;
            prev_buz = buzzer;
            if (stop_c10 > 0 && cnt10 == stop_c10 && coin_10) begin timed_out = 1'b0; break; end
            if (next) begin timed_out = 1'b0; break; end
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_pulses", {coin_100, coin_10, coin_1, next, buzzer, owe}, 32'h0);
        check("rst_change", change, 32'h000);
        check("rst_display", {ena, led}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(); tick();
        check("idle_no_action", {ena, led, change}, 32'h0);
        confirm = 1'b1; tick(); confirm = 1'b0; tick();
        check("idle_confirm_ignored", {next, ena}, 32'h0);

        // 500 - 234 = 266, full payout
        bal = 12'h500; cost = 12'h234; phase_on = 1'b1;
        tick(); tick();
        check("a_change", change, 32'h266);
        check("a_owe", owe, 32'h0);
        check("a_next_low", next, 32'h0);
        check("a_ena0", ena, 32'h1);
        check("a_led_ones6", led, 32'h7D);
        wait_ena(4'b0100, found);
        check("a_ena2_found", found, 32'h1);
        check("a_led_hund2", led, 32'h5B);
        wait_ena(4'b1000, found);
        check("a_ena3_found", found, 32'h1);
        check("a_led_C", led, 32'h39);
        confirm = 1'b1; tick(); confirm = 0;
        collect(200, 0);
        check("a_timeout", timed_out, 32'h0);
        check("a_n100", cnt100, 32'd2);
        check("a_n10", cnt10, 32'd6);
        check("a_n1", cnt1, 32'd6);
        check("a_width", width_err, 32'd0);
        check("a_gap", gap_err, 32'd0);
        check("a_order", order_err, 32'd0);
        check("a_onehot", multi_err, 32'd0);
`ifdef CHANGE_CHIRP_EN
        check("a_chirps", chirps, 32'd14);
`else
        check("a_buzzer_off", buzz_err, 32'd0);
`endif
        check("a_change_end", change, 32'h000);
        tick(); tick();
        check("a_next_hold", next, 32'h1);
        phase_on = 1'b0; tick();
        check("a_next_drop", {next, ena, change, owe}, 32'h0);

        // Exact payment
        bal = 12'h345; cost = 12'h345; phase_on = 1'b1;
        tick(); tick();
        check("b_change", {owe, change}, 32'h0);
        confirm = 1'b1; tick(); confirm = 1'b0;
        check("b_next", next, 32'h1);
        check("b_no_coin", {coin_100, coin_10, coin_1}, 32'h0);
        phase_on = 1'b0; tick();
        check("b_idle", {next, ena}, 32'h0);

        // Underpaid, inputs change after capture
        bal = 12'h120; cost = 12'h205; phase_on = 1'b1;
        tick();
        bal = 12'h999; cost = 12'h000;
        tick();
        check("c_owe", owe, 32'h1);
        check("c_change", change, 32'h085);
        wait_ena(4'b1000, found);
        check("c_ena3_found", found, 32'h1);
        check("c_led_E", led, 32'h79);
        confirm = 1'b1; tick(); confirm = 1'b0;
        check("c_next", next, 32'h1);
        check("c_no_coin", {coin_100, coin_10, coin_1}, 32'h0);
        phase_on = 1'b0; tick();

        // Digit clamp: 0F0 -> 090, 100 - 090 = 010 owed
        bal = 12'h0F0; cost = 12'h100; phase_on = 1'b1;
        tick(); tick();
        check("d_clamp", {owe, change}, 32'h1010);
        phase_on = 1'b0; tick();
        check("d_abort_clear", {owe, change, ena}, 32'h0);

        // Abort during second coin_10 pulse
        bal = 12'h030; cost = 12'h000; phase_on = 1'b1;
        tick(); tick();
        check("e_change", change, 32'h030);
        confirm = 1'b1; tick(); confirm = 1'b0;
        collect(100, 2);
        check("e_timeout", timed_out, 32'h0);
        check("e_n100", cnt100, 32'd0);
        check("e_mid_change", change, 32'h020);
        phase_on = 1'b0; tick();
        check("e_coin_drop", coin_10, 32'h0);
        check("e_idle", {change, owe, ena, led}, 32'h0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (next || coin_10 || coin_1) seen++;
            tick();
        end
        check("e_no_next", seen, 32'd0);

        // Reset mid coin_1 pulse, then fresh capture
        bal = 12'h003; cost = 12'h000; phase_on = 1'b1;
        tick(); tick();
        confirm = 1'b1; tick(); confirm = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (coin_1) begin found = 1'b1; break; end
            tick();
        end
        check("f_coin1_seen", found, 32'h1);
        tick();
        #2 rst = 1'b0;
        #1;
        check("f_async_outs", {coin_100, coin_10, coin_1, next, buzzer, owe}, 32'h0);
        check("f_async_data", {change, ena, led}, 32'h0);
        @(negedge clk);
        bal = 12'h010; cost = 12'h005;
        rst = 1'b1;
        tick(); tick();
        check("f_recapture", {owe, change}, 32'h005);
        phase_on = 1'b0; tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
